// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared DAC command constants, frame helper and scheduler state type
package dac_pkg;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam int         DAC_FRAME_W          = 24;
    localparam int         DAC_SAMPLE_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START_L = 3'd1,
        ST_WAIT_L  = 3'd2,
        ST_START_R = 3'd3,
        ST_WAIT_R  = 3'd4
    } sched_state_t;

    function automatic logic [DAC_FRAME_W-1:0] dac_frame(
        input logic [3:0]              addr,
        input logic [DAC_SAMPLE_W-1:0] sample
    );
        return {DAC_CMD_WRITE_UPDATE, addr, sample};
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running divider producing a one-cycle tick every CLK_DIV cycles
module sample_tick_gen #(
    parameter int CLK_DIV = 2267
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - stereo sample buffers feeding the SPI DAC engine, one L/R frame pair per tick
// Optional per-channel underrun counters: DAC_SCHED_UNDERRUN_CNT_EN
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int         CLK_DIV = 2267,
    parameter logic [3:0] ADDR_L  = 4'h0,
    parameter logic [3:0] ADDR_R  = 4'h1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DAC_SAMPLE_W-1:0] l_data,
    input  logic                    l_valid,
    output logic                    l_ready,
    input  logic [DAC_SAMPLE_W-1:0] r_data,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic [DAC_FRAME_W-1:0]  dac_word,
    output logic                    dac_start,
    input  logic                    dac_done,
    output logic [1:0]              underrun,
    output logic                    overrun
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             l_urun_cnt,
    output logic [15:0]             r_urun_cnt
`endif
);

    logic                    tick;
    logic                    accept;
    sched_state_t            state;
    logic                    l_full, r_full;
    logic [DAC_SAMPLE_W-1:0] l_buf, r_buf;
    logic [DAC_SAMPLE_W-1:0] frame_l, frame_r;

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    // Ready is gated by RST so the source sees no acceptance while the block is held in reset.
    assign l_ready = !RST && !l_full;
    assign r_ready = !RST && !r_full;
    assign accept  = tick && (state == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            l_full    <= 1'b0;
            r_full    <= 1'b0;
            l_buf     <= '0;
            r_buf     <= '0;
            frame_l   <= '0;
            frame_r   <= '0;
            dac_word  <= '0;
            dac_start <= 1'b0;
            underrun  <= 2'b00;
            overrun   <= 1'b0;
        end else begin
            // A handshake in the tick cycle refills the buffer for the following tick.
            if (l_valid && !l_full) begin
                l_buf  <= l_data;
                l_full <= 1'b1;
            end else if (accept) begin
                l_full <= 1'b0;
            end
            if (r_valid && !r_full) begin
                r_buf  <= r_data;
                r_full <= 1'b1;
            end else if (accept) begin
                r_full <= 1'b0;
            end

            if (tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        if (l_full) frame_l <= l_buf;
                        else        underrun[0] <= 1'b1;
                        if (r_full) frame_r <= r_buf;
                        else        underrun[1] <= 1'b1;
                        dac_word  <= dac_frame(ADDR_L, l_full ? l_buf : frame_l);
                        dac_start <= 1'b1;
                        state     <= ST_START_L;
                    end
                end
                ST_START_L: begin
                    dac_start <= 1'b0;
                    state     <= ST_WAIT_L;
                end
                ST_WAIT_L: begin
                    if (dac_done) begin
                        dac_word  <= dac_frame(ADDR_R, frame_r);
                        dac_start <= 1'b1;
                        state     <= ST_START_R;
                    end
                end
                ST_START_R: begin
                    dac_start <= 1'b0;
                    state     <= ST_WAIT_R;
                end
                ST_WAIT_R: begin
                    if (dac_done) state <= ST_IDLE;
                end
                default: begin
                    dac_start <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            l_urun_cnt <= '0;
            r_urun_cnt <= '0;
        end else if (accept) begin
            if (!l_full && l_urun_cnt != 16'hFFFF) l_urun_cnt <= l_urun_cnt + 16'd1;
            if (!r_full && r_urun_cnt != 16'hFFFF) r_urun_cnt <= r_urun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb/tb_dac_frame_scheduler.sv - scoreboard bench for dac_frame_scheduler with a timing-level reference model
module tb_dac_frame_scheduler;

    localparam int DIV = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] l_data = '0, r_data = '0;
    logic        l_valid = 1'b0, r_valid = 1'b0;
    logic        l_ready, r_ready;
    logic [23:0] dac_word;
    logic        dac_start;
    logic        dac_done = 1'b0;
    logic [1:0]  underrun;
    logic        overrun;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [15:0] l_urun_cnt, r_urun_cnt;
`endif

    dac_frame_scheduler #(.CLK_DIV(DIV), .ADDR_L(4'h0), .ADDR_R(4'h1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .l_data     (l_data),
        .l_valid    (l_valid),
        .l_ready    (l_ready),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .dac_word   (dac_word),
        .dac_start  (dac_start),
        .dac_done   (dac_done),
        .underrun   (underrun),
        .overrun    (overrun)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
        ,
        .l_urun_cnt (l_urun_cnt),
        .r_urun_cnt (r_urun_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [23:0] w;
        int          c;
    } exp_t;
    exp_t expq[$];

    // Reference model: tick times, busy window and buffer contents as plain numbers
    bit          m_lfull, m_rfull, m_or;
    logic [15:0] m_lbuf, m_rbuf, m_fl, m_fr;
    logic [1:0]  m_ur;
    int          m_busy, m_lcnt, m_rcnt, n;
    int          dly = 3;
    bit          spur_en = 0;
    logic [15:0] lq[$], rq[$];
    int          l_gate = 0, r_gate = 0, offer_pct = 100;
    bit          lx, rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        if (lx) l_valid = 1'b0;
        if (rx) r_valid = 1'b0;
        lx = 0;
        rx = 0;
        if (!l_valid) l_data = 16'($urandom);
        if (!r_valid) r_data = 16'($urandom);
        if (!l_valid && lq.size() > 0 && n >= l_gate && $urandom_range(0, 99) < offer_pct) begin
            l_valid = 1'b1;
            l_data  = lq.pop_front();
        end
        if (!r_valid && rq.size() > 0 && n >= r_gate && $urandom_range(0, 99) < offer_pct) begin
            r_valid = 1'b1;
            r_data  = rq.pop_front();
        end
    endtask

    task automatic step();
        bit xl, xr;
        drive_inputs();
        #1;
        check("l_ready", l_ready, !m_lfull);
        check("r_ready", r_ready, !m_rfull);
        check("underrun", underrun, m_ur);
        check("overrun", overrun, m_or);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
        check("l_urun_cnt", l_urun_cnt, m_lcnt[15:0]);
        check("r_urun_cnt", r_urun_cnt, m_rcnt[15:0]);
`endif
        xl = l_valid && !m_lfull;
        xr = r_valid && !m_rfull;
        lx = xl;
        rx = xr;
        if (n % DIV == DIV - 1) begin
            if (cyc >= m_busy) begin
                if (m_lfull) m_fl = m_lbuf;
                else begin
                    m_ur[0] = 1'b1;
                    if (m_lcnt < 65535) m_lcnt++;
                end
                if (m_rfull) m_fr = m_rbuf;
                else begin
                    m_ur[1] = 1'b1;
                    if (m_rcnt < 65535) m_rcnt++;
                end
                expq.push_back('{{4'h3, 4'h0, m_fl}, cyc + 1});
                expq.push_back('{{4'h3, 4'h1, m_fr}, cyc + dly + 2});
                m_busy  = cyc + 2 * dly + 3;
                m_lfull = 0;
                m_rfull = 0;
            end else begin
                m_or = 1'b1;
            end
        end
        if (xl) begin m_lfull = 1; m_lbuf = l_data; end
        if (xr) begin m_rfull = 1; m_rbuf = r_data; end
        n++;
        @(negedge CLK);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset(input int k);
        exp_t keep[$];
        n = 0;
        for (int i = 0; i < k; i++) begin
            RST = 1'b1;
            if (i == 0) begin
                foreach (expq[j]) if (expq[j].c <= cyc) keep.push_back(expq[j]);
                expq = keep;
            end
            drive_inputs();
            #1;
            check("l_ready_rst", l_ready, 1'b0);
            check("r_ready_rst", r_ready, 1'b0);
            @(negedge CLK);
        end
        RST     = 1'b0;
        m_lfull = 0; m_rfull = 0; m_or = 0; m_ur = 2'b00;
        m_lbuf  = '0; m_rbuf = '0; m_fl = '0; m_fr = '0;
        m_busy  = 0; m_lcnt = 0; m_rcnt = 0;
        lx = 0; rx = 0;
    endtask

    // Engine model: dac_done follows a start by dly cycles; optional stray pulses while not counting
    initial begin
        int ecnt = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                ecnt     = 0;
                dac_done = 1'b0;
            end else begin
                dac_done = 1'b0;
                if (ecnt > 0) begin
                    ecnt--;
                    if (ecnt == 0) dac_done = 1'b1;
                end else if (spur_en && $urandom_range(0, 7) == 0) begin
                    dac_done = 1'b1;
                end
                if (dac_start) ecnt = dly;
            end
        end
    end

    // Monitor: every start must match the oldest expected frame in word and cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (expq.size() > 0 && expq[0].c < cyc) begin
                e = expq.pop_front();
                checks++;
                fails++;
                $display("FAIL missing_start: no dac_start for word %h, required at cycle %0d", e.w, e.c);
            end
            if (dac_start) begin
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_start: word %h at cycle %0d, required none", dac_word, cyc);
                end else begin
                    e = expq.pop_front();
                    check("dac_word", dac_word, e.w);
                    check("start_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // Basic frame pair, reset held with valid asserted
        lq.push_back(16'h1234);
        rq.push_back(16'hABCD);
        dly = 3;
        do_reset(3);
        run(30);

        // Two ticks with no samples
        do_reset(2);
        run(45);

        // Left sample offered exactly on the tick cycle
        l_gate = 15;
        lq.push_back(16'h5555);
        rq.push_back(16'h6666);
        do_reset(1);
        run(40);
        l_gate = 0;

        // Slow engine: overrun and dropped ticks
        dly = 20;
        for (int i = 0; i < 8; i++) begin
            lq.push_back(16'($urandom));
            rq.push_back(16'($urandom));
        end
        do_reset(1);
        run(150);

        // Reset while waiting for the left frame
        dly = 5;
        lq.delete();
        rq.delete();
        lq.push_back(16'h0F0F);
        rq.push_back(16'hF0F0);
        do_reset(1);
        run(18);
        lq.push_back(16'h2222);
        rq.push_back(16'h3333);
        do_reset(1);
        run(40);

        // Randomized traffic with stray done pulses
        spur_en = 1;
        for (int k = 0; k < 8; k++) begin
            dly       = $urandom_range(1, 8);
            offer_pct = $urandom_range(20, 100);
            lq.delete();
            rq.delete();
            for (int i = 0; i < 12; i++) begin
                lq.push_back(16'($urandom));
                rq.push_back(16'($urandom));
            end
            do_reset($urandom_range(1, 3));
            run($urandom_range(60, 200));
        end

        // Drain the last frame pair and confirm nothing is left outstanding
        spur_en = 0;
        lq.delete();
        rq.delete();
        guard = 0;
        while (cyc < m_busy && guard < 200) begin
            step();
            guard++;
        end
        check("drain_in_time", (guard < 200), 1'b1);
        check("queue_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
